// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiply sequencer that borrows the shared ALU (ADD/LSL).
// Optional build macro: MUL_EARLY_EXIT_EN stops the loop after the highest set multiplier bit.

`ifndef FLAGS_C
`define FLAGS_C 1
`endif

package opcodes;
    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        LSL = 4'd5,
        LSR = 4'd6,
        ASR = 4'd7
    } Opcode_t;
endpackage

module alu_mul_seq (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [15:0]      OpA,
    input  logic [15:0]      OpB,
    output logic             Busy,
    output logic             Done,
    output logic [15:0]      Product,
    output logic             Overflow,
    output logic             AluReq,
    output logic [15:0]      AluOp1,
    output logic [15:0]      AluOp2,
    output opcodes::Opcode_t AluOpCode,
    output logic             AluCarryIn,
    input  logic [15:0]      AluResult,
    input  logic [3:0]       AluFlags
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef MUL_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    // Another SHIFT is needed unless the counter is exhausted (or, early exit, no bits remain).
    function automatic logic more_f(input logic [14:0] mp_hi, input logic [3:0] cnt);
        return (cnt != 4'd15) && (!EARLY_EXIT || (mp_hi != 15'd0));
    endfunction

    state_t            state_r, state_s;
    logic [15:0]       acc_r, acc_s;
    logic [15:0]       mcand_r, mcand_s;
    logic [15:0]       mplier_r, mplier_s;
    logic [3:0]        count_r, count_s;
    logic              ovf_r, ovf_s;
    logic [15:0]       op1_s, op2_s;
    opcodes::Opcode_t  opc_s;
    logic [15:0]       mplier_shr_s;
    logic              unused_flags_s;

    assign mplier_shr_s   = mplier_r >> 1;
    assign unused_flags_s = ^AluFlags;
    assign AluCarryIn     = 1'b0;

    // Next-state and datapath update for the shift-and-add loop.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        count_s  = count_r;
        ovf_s    = ovf_r;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    acc_s    = 16'd0;
                    mcand_s  = OpA;
                    mplier_s = OpB;
                    count_s  = 4'd0;
                    ovf_s    = 1'b0;
                    if (OpB[0]) begin
                        state_s = S_ADD;
                    end else if (more_f(OpB[15:1], 4'd0)) begin
                        state_s = S_SHIFT;
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADD: begin
                acc_s = AluResult;
                ovf_s = ovf_r | AluFlags[`FLAGS_C];
                if (more_f(mplier_r[15:1], count_r)) begin
                    state_s = S_SHIFT;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_SHIFT: begin
                mcand_s  = AluResult;
                mplier_s = mplier_shr_s;
                count_s  = count_r + 4'd1;
                // A bit shifted out of Mcand is lost product if any multiplier bit is still pending.
                ovf_s    = ovf_r | (mcand_r[15] & (mplier_shr_s != 16'd0));
                if (mplier_shr_s[0]) begin
                    state_s = S_ADD;
                end else if (more_f(mplier_shr_s[15:1], count_s)) begin
                    state_s = S_SHIFT;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // ALU operands for the state being entered, so the registered outputs line up with it.
    always_comb begin
        op1_s = 16'd0;
        op2_s = 16'd0;
        opc_s = opcodes::ADD;
        case (state_s)
            S_ADD: begin
                op1_s = acc_s;
                op2_s = mcand_s;
                opc_s = opcodes::ADD;
            end
            S_SHIFT: begin
                op1_s = mcand_s;
                op2_s = 16'd1;
                opc_s = opcodes::LSL;
            end
            default: begin
                op1_s = 16'd0;
                op2_s = 16'd0;
                opc_s = opcodes::ADD;
            end
        endcase
    end

    // State, datapath and registered output update.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= S_IDLE;
            acc_r     <= 16'd0;
            mcand_r   <= 16'd0;
            mplier_r  <= 16'd0;
            count_r   <= 4'd0;
            ovf_r     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            AluReq    <= 1'b0;
            AluOp1    <= 16'd0;
            AluOp2    <= 16'd0;
            AluOpCode <= opcodes::ADD;
            Product   <= 16'd0;
            Overflow  <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            mcand_r   <= mcand_s;
            mplier_r  <= mplier_s;
            count_r   <= count_s;
            ovf_r     <= ovf_s;
            Busy      <= (state_s != S_IDLE);
            Done      <= (state_s == S_DONE);
            AluReq    <= (state_s == S_ADD) || (state_s == S_SHIFT);
            AluOp1    <= op1_s;
            AluOp2    <= op2_s;
            AluOpCode <= opc_s;
            if (state_s == S_DONE) begin
                Product  <= acc_s;
                Overflow <= ovf_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: vector table plus multi-cycle corner sequences.

`ifndef FLAGS_C
`define FLAGS_C 1
`endif

module tb_alu_mul_seq;

    logic             Clock;
    logic             Reset;
    logic             Start;
    logic [15:0]      OpA;
    logic [15:0]      OpB;
    logic             Busy;
    logic             Done;
    logic [15:0]      Product;
    logic             Overflow;
    logic             AluReq;
    logic [15:0]      AluOp1;
    logic [15:0]      AluOp2;
    opcodes::Opcode_t AluOpCode;
    logic             AluCarryIn;
    logic [15:0]      AluResult;
    logic [3:0]       AluFlags;

    alu_mul_seq dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
        .Busy(Busy), .Done(Done), .Product(Product), .Overflow(Overflow),
        .AluReq(AluReq), .AluOp1(AluOp1), .AluOp2(AluOp2), .AluOpCode(AluOpCode),
        .AluCarryIn(AluCarryIn), .AluResult(AluResult), .AluFlags(AluFlags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Combinational model of the shared ALU.
    logic [16:0] sum_s;
    always_comb begin
        sum_s     = {1'b0, AluOp1} + {1'b0, AluOp2};
        AluResult = 16'd0;
        AluFlags  = 4'd0;
        case (AluOpCode)
            opcodes::ADD: begin
                AluResult          = sum_s[15:0];
                AluFlags[`FLAGS_C] = sum_s[16];
            end
            opcodes::LSL: AluResult = AluOp1 << AluOp2[3:0];
            default:      AluResult = 16'd0;
        endcase
    end

    int n_checks = 0;
    int n_pass   = 0;
    int carry_seen = 0;
    logic [3:0]  tr_opc [0:64];
    logic [15:0] tr_op1 [0:64];
    logic [15:0] tr_op2 [0:64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected cycles from accept edge to Done, from the popcount/highest-bit rule.
    function automatic int exp_lat(input logic [15:0] b);
        int pc;
        int h;
        pc = $countones(b);
        h  = 0;
        for (int i = 0; i < 16; i++) if (b[i]) h = i;
`ifdef MUL_EARLY_EXIT_EN
        if (b == 16'd0) return 1;
        return h + pc + 1;
`else
        return 16 + pc + (h - h);
`endif
    endfunction

    // Issue Start from an IDLE-cycle negedge; return on the Done cycle's negedge.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int poke,
                           output int lat, output int reqcnt);
        lat    = 0;
        reqcnt = 0;
        OpA    = a;
        OpB    = b;
        Start  = 1'b1;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(negedge Clock);
            if (cyc == poke) begin
                Start = 1'b1;
                OpA   = 16'd1;
                OpB   = 16'd1;
            end else begin
                Start = 1'b0;
            end
            tr_opc[cyc] = AluOpCode;
            tr_op1[cyc] = AluOp1;
            tr_op2[cyc] = AluOp2;
            if (AluReq) reqcnt++;
            if (AluCarryIn) carry_seen++;
            if (Done) begin
                lat = cyc;
                break;
            end
        end
        Start = 1'b0;
        if (lat == 0) $display("FAIL done_timeout: got no Done, expected Done within 64 cycles");
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        logic        ovf;
    } vec_t;

    vec_t vecs [9];
    int lat;
    int req;
    int done_cnt;

    initial begin
        vecs[0] = '{16'd5,     16'd3,     16'd15,    1'b0};
        vecs[1] = '{16'h0100,  16'h0100,  16'h0000,  1'b1};
        vecs[2] = '{16'hFFFF,  16'h0003,  16'hFFFD,  1'b1};
        vecs[3] = '{16'h1234,  16'h0000,  16'h0000,  1'b0};
        vecs[4] = '{16'h00FF,  16'h0101,  16'hFFFF,  1'b0};
        vecs[5] = '{16'h8000,  16'h0001,  16'h8000,  1'b0};
        vecs[6] = '{16'h8000,  16'h0002,  16'h0000,  1'b1};
        vecs[7] = '{16'd7,     16'd9,     16'd63,    1'b0};
        vecs[8] = '{16'hFFFF,  16'hFFFF,  16'h0001,  1'b1};

        Reset = 1'b1;
        Start = 1'b0;
        OpA   = 16'd0;
        OpB   = 16'd0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        chk("rst_busy",     {31'd0, Busy},       32'd0);
        chk("rst_done",     {31'd0, Done},       32'd0);
        chk("rst_alureq",   {31'd0, AluReq},     32'd0);
        chk("rst_product",  {16'd0, Product},    32'd0);
        chk("rst_overflow", {31'd0, Overflow},   32'd0);
        chk("rst_carryin",  {31'd0, AluCarryIn}, 32'd0);
        chk("rst_op1",      {16'd0, AluOp1},     32'd0);
        chk("rst_op2",      {16'd0, AluOp2},     32'd0);
        chk("rst_opcode",   {28'd0, AluOpCode},  {28'd0, 4'd0});

        // 7x9 with a Start pulse at cycle 3 that must be ignored.
        run_mul(16'd7, 16'd9, 3, lat, req);
        chk("c1_opcode", {28'd0, tr_opc[1]}, 32'd0);
        chk("c1_op1",    {16'd0, tr_op1[1]}, 32'd0);
        chk("c1_op2",    {16'd0, tr_op2[1]}, 32'd7);
        chk("c2_opcode", {28'd0, tr_opc[2]}, 32'd5);
        chk("c2_op1",    {16'd0, tr_op1[2]}, 32'd7);
        chk("c2_op2",    {16'd0, tr_op2[2]}, 32'd1);
        chk("poke_latency", lat, exp_lat(16'd9));
        @(negedge Clock);
        chk("poke_product",  {16'd0, Product},  32'd63);
        chk("poke_overflow", {31'd0, Overflow}, 32'd0);

        // Table vectors, each Start issued in the IDLE cycle right after the previous Done.
        for (int i = 0; i < 9; i++) begin
            chk("idle_busy", {31'd0, Busy}, 32'd0);
            run_mul(vecs[i].a, vecs[i].b, 0, lat, req);
            chk("latency", lat, exp_lat(vecs[i].b));
            chk("alureq_cycles", req, exp_lat(vecs[i].b) - 1);
            @(negedge Clock);
            chk("product",  {16'd0, Product},  {16'd0, vecs[i].prod});
            chk("overflow", {31'd0, Overflow}, {31'd0, vecs[i].ovf});
        end

        // Reset during a SHIFT cycle of 9x9 aborts and clears the result.
        OpA   = 16'd9;
        OpB   = 16'd9;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        chk("pre_rst_shift", {28'd0, AluOpCode}, 32'd5);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("abort_busy",     {31'd0, Busy},     32'd0);
        chk("abort_alureq",   {31'd0, AluReq},   32'd0);
        chk("abort_product",  {16'd0, Product},  32'd0);
        chk("abort_overflow", {31'd0, Overflow}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (Done) done_cnt++;
            @(negedge Clock);
        end
        chk("abort_no_done", done_cnt, 0);
        run_mul(16'd2, 16'd4, 0, lat, req);
        chk("after_abort_latency", lat, exp_lat(16'd4));
        @(negedge Clock);
        chk("after_abort_product", {16'd0, Product}, 32'd8);
        chk("carryin_never_set", carry_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
